mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the five-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and Data_Memory, and it also holds the MEM/WB pipeline register.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses on the single-port, word-wide Data_Memory.
- Sub-word stores use a two-cycle read-modify-write (RMW). Loads are extracted and sign/zero-extended, then registered toward writeback.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TRAP_MISALIGNED, 1, 1: misaligned access is suppressed and flagged; 0: low address bits are ignored (force-aligned)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  EX/MEM holds a live instruction
mem_read_i  in  1  instruction is a load
mem_write_i  in  1  instruction is a store
funct3_i  in  3  RV32I load/store funct3
alu_result_i  in  XLEN  effective byte address, or ALU result for non-memory ops
store_data_i  in  XLEN  rs2 value
rd_i  in  5  destination register
reg_write_i  in  1  instruction writes rd
flush_i  in  1  squash the instruction currently in MEM
dm_addr_o  out  XLEN  to Data_Memory A; always {addr[31:2],2'b00}
dm_we_o  out  1  to Data_Memory WE
dm_wd_o  out  XLEN  to Data_Memory WD
dm_rd_i  in  XLEN  from Data_Memory RD; combinational read of dm_addr_o
stall_o  out  1  holds the EX/MEM register and earlier stages
wb_valid_o  out  1  MEM/WB register valid
wb_reg_write_o  out  1  registered write enable for rd
wb_mem_to_reg_o  out  1  registered; 1 selects wb_load_data_o
wb_rd_o  out  5  registered rd
wb_alu_result_o  out  XLEN  registered ALU result
wb_load_data_o  out  XLEN  registered, extended load data
misalign_o  out  1  one-cycle registered pulse on a misaligned access

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM returns to IDLE; all wb_* outputs, misalign_o and the merge register are cleared to 0.
  - stall_o and dm_we_o are driven 0 whenever rst=1.
- Memory interface:
  - Little-endian byte lane = addr[1:0].
  - dm_addr_o and dm_wd_o are combinational from the inputs or the RMW registers.
- FSM states: IDLE, RMW_WR.
- IDLE, load (valid_i & mem_read_i, aligned):
  - dm_we_o=0.
  - dm_rd_i lane extracted: LB/LH sign-extend, LBU/LHU zero-extend.
  - Registered into wb_load_data_o at the next edge with wb_mem_to_reg_o=1. Load-to-WB latency is 1 cycle.
- IDLE, SW (aligned): dm_we_o=1 and dm_wd_o=store_data_i in the same cycle; no stall.
- IDLE, SB/SH (aligned):
  - dm_we_o=0 and stall_o=1.
  - Merge register <= dm_rd_i with the addressed lane(s) replaced by store_data_i[7:0] or [15:0]. Latch the address and go to RMW_WR.
  - MEM/WB receives a bubble (wb_valid_o=0).
- RMW_WR:
  - dm_we_o=1, dm_addr_o=latched address, dm_wd_o=merge register, stall_o=0.
  - Return to IDLE; MEM/WB captures the store (wb_reg_write_o=0).
- Non-memory instruction: passes alu_result_i, rd_i and reg_write_i into MEM/WB in 1 cycle, with wb_mem_to_reg_o=0.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0), when TRAP_MISALIGNED=1:
  - No dm_we_o, no RMW.
  - misalign_o=1 next cycle; MEM/WB valid=1 with wb_reg_write_o=0.
- Unsupported funct3 (011, 110, 111) with a memory op: treated as misaligned.
- valid_i=0: MEM/WB loads a bubble; dm_we_o=0.
- flush_i in IDLE: no memory write, no stall, MEM/WB bubble. flush_i in RMW_WR is ignored and the store completes.
- rst in RMW_WR: write aborted (dm_we_o=0), FSM to IDLE.
- Inputs are stable while stall_o=1, because the upstream register holds.

Decomposition:
- Shared package riscv_pkg: funct3 constants (F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010) and the FSM state encoding.
- One sub-module, load_extract: combinational lane select plus sign/zero-extend, (dm_rd, addr[1:0], funct3) -> data. Reused by the bench's reference model.

Test Plan:
- SW addr 4 data 0xAAAA5555 -> same cycle dm_we_o=1, dm_addr_o=4, dm_wd_o=0xAAAA5555; stall_o never asserted.
- With mem[4]=0xAAAA5555:
  - LB addr 6 -> wb_load_data_o=0xFFFFFFAA.
  - LBU addr 6 -> 0x000000AA.
  - LH addr 4 -> 0x00005555.
  - LHU addr 6 -> 0x0000AAAA.
  - Each appears one cycle later with wb_mem_to_reg_o=1.
- With mem[4]=0xAAAA5555, SB addr 5 data 0x00000123:
  - Cycle 1: stall_o=1, dm_we_o=0, wb_valid_o=0 next.
  - Cycle 2: dm_we_o=1, dm_wd_o=0xAAAA2355.
  - Readback LW addr 4 = 0xAAAA2355.
- SH addr 3 data 0xBEEF -> dm_we_o never 1, misalign_o pulses 1 cycle, wb_reg_write_o=0, memory unchanged.
- SH addr 8 data 0xDEADBEEF with rst=1 during RMW_WR -> no write, mem[8] unchanged, FSM IDLE, all wb_* = 0.
- flush_i=1 with SW addr 8 in IDLE -> dm_we_o=0, wb_valid_o=0. flush_i=1 during RMW_WR of SB -> write still completes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store funct3 encodings and the MEM-stage FSM state type.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RMW_WR = 1'b1
   } mau_state_e;

   function automatic logic f3_unsupported(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide single-port Data_Memory bus between the MEM stage and the memory.
interface mem_access_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] dm_addr;
   logic            dm_we;
   logic [XLEN-1:0] dm_wd;
   logic [XLEN-1:0] dm_rd;

   modport master (output dm_addr, output dm_we, output dm_wd, input dm_rd);
   modport slave  (input dm_addr, input dm_we, input dm_wd, output dm_rd);
endinterface

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword lane of a memory word and sign/zero-extends it.
module load_extract
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rd_data,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rd_data >> {off, 3'b000};
      data    = rd_data;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: data = rd_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word accesses to Data_Memory, sub-word store RMW,
// load extraction, and the MEM/WB pipeline register.
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN            = 32,
   parameter bit          TRAP_MISALIGNED = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic                 mem_read_i,
   input  logic                 mem_write_i,
   input  logic [2:0]           funct3_i,
   input  logic [XLEN-1:0]      alu_result_i,
   input  logic [XLEN-1:0]      store_data_i,
   input  logic [4:0]           rd_i,
   input  logic                 reg_write_i,
   input  logic                 flush_i,
   mem_access_unit_if.master    dm,
   output logic                 stall_o,
   output logic                 wb_valid_o,
   output logic                 wb_reg_write_o,
   output logic                 wb_mem_to_reg_o,
   output logic [4:0]           wb_rd_o,
   output logic [XLEN-1:0]      wb_alu_result_o,
   output logic [XLEN-1:0]      wb_load_data_o,
   output logic                 misalign_o
);

   mau_state_e      state_q, state_d;
   logic [XLEN-1:0] merge_q, merge_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            wb_valid_q, wb_valid_d;
   logic            wb_rw_q, wb_rw_d;
   logic            wb_m2r_q, wb_m2r_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_alu_q, wb_alu_d;
   logic [XLEN-1:0] wb_ld_q, wb_ld_d;
   logic            mis_q, mis_d;

   logic [1:0]      size;
   logic            mem_op, mis_raw, bad, live;
   logic [1:0]      off;
   logic [XLEN-1:0] ld_data, lane_mask, merged;

   assign size    = funct3_i[1:0];
   assign mem_op  = mem_read_i | mem_write_i;
   assign mis_raw = ((size == 2'b01) && alu_result_i[0]) ||
                    ((size == 2'b10) && (alu_result_i[1:0] != 2'b00));
   // Stores have no funct3[2] variant, so 100/101 on a store are illegal too.
   assign bad     = mem_op & (f3_unsupported(funct3_i) | (mem_write_i & funct3_i[2]) |
                              (TRAP_MISALIGNED & mis_raw));
   assign live    = valid_i & ~flush_i;

   always_comb begin
      off = alu_result_i[1:0];
      if (!TRAP_MISALIGNED) begin
         if (size == 2'b01)      off = {alu_result_i[1], 1'b0};
         else if (size == 2'b10) off = 2'b00;
      end
   end

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .rd_data (dm.dm_rd),
      .off     (off),
      .funct3  (funct3_i),
      .data    (ld_data)
   );

   assign lane_mask = ((size == 2'b00) ? {{(XLEN-8){1'b0}}, 8'hFF}
                                       : {{(XLEN-16){1'b0}}, 16'hFFFF}) << {off, 3'b000};
   assign merged    = (dm.dm_rd & ~lane_mask) | ((store_data_i << {off, 3'b000}) & lane_mask);

   always_comb begin
      state_d    = state_q;
      merge_d    = merge_q;
      addr_d     = addr_q;
      dm.dm_addr = {alu_result_i[XLEN-1:2], 2'b00};
      dm.dm_we   = 1'b0;
      dm.dm_wd   = store_data_i;
      stall_o    = 1'b0;
      wb_valid_d = 1'b0;
      wb_rw_d    = 1'b0;
      wb_m2r_d   = 1'b0;
      wb_rd_d    = '0;
      wb_alu_d   = '0;
      wb_ld_d    = '0;
      mis_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (live) begin
               if (mem_write_i && !bad && (size != 2'b10)) begin
                  stall_o = 1'b1;
                  merge_d = merged;
                  addr_d  = {alu_result_i[XLEN-1:2], 2'b00};
                  state_d = ST_RMW_WR;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_i;
                  wb_alu_d   = alu_result_i;
                  mis_d      = bad;
                  wb_rw_d    = reg_write_i & ~mem_write_i & ~bad;
                  wb_m2r_d   = mem_read_i & ~mem_write_i & ~bad;
                  wb_ld_d    = wb_m2r_d ? ld_data : '0;
                  dm.dm_we   = mem_write_i & ~bad;
               end
            end
         end
         ST_RMW_WR: begin
            // Upstream is held, so rd_i/alu_result_i still describe this store.
            dm.dm_addr = addr_q;
            dm.dm_we   = 1'b1;
            dm.dm_wd   = merge_q;
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_alu_d   = alu_result_i;
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst) begin
         dm.dm_we = 1'b0;
         stall_o  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         merge_q    <= '0;
         addr_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
         wb_rd_q    <= '0;
         wb_alu_q   <= '0;
         wb_ld_q    <= '0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         merge_q    <= merge_d;
         addr_q     <= addr_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
         wb_rd_q    <= wb_rd_d;
         wb_alu_q   <= wb_alu_d;
         wb_ld_q    <= wb_ld_d;
         mis_q      <= mis_d;
      end
   end

   assign wb_valid_o      = wb_valid_q;
   assign wb_reg_write_o  = wb_rw_q;
   assign wb_mem_to_reg_o = wb_m2r_q;
   assign wb_rd_o         = wb_rd_q;
   assign wb_alu_result_o = wb_alu_q;
   assign wb_load_data_o  = wb_ld_q;
   assign misalign_o      = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/flush corner sequences,
// then random instructions checked against a byte-level memory model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, mrd = 1'b0, mwr = 1'b0, rwi = 1'b0, flush = 1'b0;
   logic [2:0]  f3 = 3'b000;
   logic [31:0] alu = '0, sd = '0;
   logic [4:0]  rd = '0;
   logic        stall, wbv, wbrw, wbm2r, mis;
   logic [4:0]  wbrd;
   logic [31:0] wbalu, wbld;

   always #5 clk = ~clk;

   mem_access_unit_if #(.XLEN(32)) dmif ();

   mem_access_unit #(.XLEN(32), .TRAP_MISALIGNED(1'b1)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_i         (valid),
      .mem_read_i      (mrd),
      .mem_write_i     (mwr),
      .funct3_i        (f3),
      .alu_result_i    (alu),
      .store_data_i    (sd),
      .rd_i            (rd),
      .reg_write_i     (rwi),
      .flush_i         (flush),
      .dm              (dmif),
      .stall_o         (stall),
      .wb_valid_o      (wbv),
      .wb_reg_write_o  (wbrw),
      .wb_mem_to_reg_o (wbm2r),
      .wb_rd_o         (wbrd),
      .wb_alu_result_o (wbalu),
      .wb_load_data_o  (wbld),
      .misalign_o      (mis)
   );

   logic [31:0] mem  [16] = '{default: 32'h0};
   logic [31:0] gmem [16];

   assign dmif.dm_rd = mem[dmif.dm_addr[5:2]];
   always @(posedge clk) if (dmif.dm_we) mem[dmif.dm_addr[5:2]] <= dmif.dm_wd;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Observed behaviour of one instruction
   logic        ob_stall, ob_we1, ob_we2, ob_bub, ob_stall2;
   logic [31:0] ob_wd, ob_addr;
   // Model expectations for one instruction
   logic        e_stall, e_write, e_wbv, e_rw, e_m2r, e_mis;
   logic [31:0] e_ld, e_alu;
   logic [4:0]  e_rd;

   task automatic model(input int kind, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r, input logic rw,
                        input logic fl, input logic vl);
      logic [1:0]  sz;
      logic        memop, isbad, live;
      logic [31:0] w, v;
      int          nb, k;
      sz    = fn[1:0];
      memop = (kind != 0);
      isbad = memop && (fn == 3'd3 || fn == 3'd6 || fn == 3'd7 ||
                        (kind == 2 && fn[2]) ||
                        (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
      live  = vl && !fl;
      e_wbv   = live;
      e_rd    = live ? r : 5'd0;
      e_alu   = live ? a : 32'd0;
      e_mis   = live && isbad;
      e_rw    = live && kind != 2 && !isbad && rw;
      e_m2r   = live && kind == 1 && !isbad;
      e_write = live && kind == 2 && !isbad;
      e_stall = e_write && sz != 2'd2;
      e_ld    = 32'd0;
      w = gmem[a[5:2]];
      if (e_m2r) begin
         v = w >> (8 * a[1:0]);
         if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!fn[2] && v[7]) v = v | 32'hFFFFFF00;
         end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!fn[2] && v[15]) v = v | 32'hFFFF0000;
         end
         e_ld = v;
      end
      if (e_write) begin
         nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         for (int i = 0; i < nb; i++) begin
            k = int'(a[1:0]) + i;
            w[8*k +: 8] = d[8*i +: 8];
         end
         gmem[a[5:2]] = w;
      end
   endtask

   task automatic issue(input int kind, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r, input logic rw,
                        input logic fl, input logic fl2, input logic vl);
      model(kind, fn, a, d, r, rw, fl, vl);
      valid = vl; mrd = (kind == 1); mwr = (kind == 2); f3 = fn;
      alu = a; sd = d; rd = r; rwi = rw; flush = fl;
      #4;
      ob_stall = stall; ob_we1 = dmif.dm_we; ob_wd = dmif.dm_wd; ob_addr = dmif.dm_addr;
      ob_we2 = 1'b0; ob_bub = 1'b0; ob_stall2 = 1'b0;
      @(posedge clk); #1;
      if (ob_stall) begin
         ob_bub = wbv;
         flush  = fl2;
         #3;
         ob_we2 = dmif.dm_we; ob_stall2 = stall;
         if (dmif.dm_we) begin ob_wd = dmif.dm_wd; ob_addr = dmif.dm_addr; end
         @(posedge clk); #1;
      end
      valid = 1'b0; flush = 1'b0; mrd = 1'b0; mwr = 1'b0;
   endtask

   task automatic chk_mem(input string nm);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 16; i++) if (mem[i] !== gmem[i]) ok = 1'b0;
      chk(nm, {31'd0, ok}, 32'd1);
   endtask

   typedef struct {
      int          kind;   // 0 alu, 1 load, 2 store
      logic [2:0]  fn;
      logic [31:0] a, d;
      logic        fl, fl2;
      logic        x_stall, x_we1, x_we2;
      logic [31:0] x_wd;
      logic        x_wbv, x_m2r;
      logic [31:0] x_ld;
      logic        x_mis;
   } vec_t;

   vec_t vt [14];

   initial begin
      for (int i = 0; i < 16; i++) gmem[i] = 32'h0;
      //           kind fn      addr          data          fl  fl2 stl we1 we2 wd            wbv m2r ld            mis
      vt[0]  = '{2, 3'b010, 32'h4, 32'hAAAA5555, 0, 0, 0, 1, 0, 32'hAAAA5555, 1, 0, 32'h0,        0};
      vt[1]  = '{1, 3'b000, 32'h6, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'hFFFFFFAA, 0};
      vt[2]  = '{1, 3'b100, 32'h6, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h000000AA, 0};
      vt[3]  = '{1, 3'b001, 32'h4, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h00005555, 0};
      vt[4]  = '{1, 3'b101, 32'h6, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h0000AAAA, 0};
      vt[5]  = '{2, 3'b000, 32'h5, 32'h00000123, 0, 0, 1, 0, 1, 32'hAAAA2355, 1, 0, 32'h0,        0};
      vt[6]  = '{1, 3'b010, 32'h4, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'hAAAA2355, 0};
      vt[7]  = '{2, 3'b001, 32'h3, 32'h0000BEEF, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1};
      vt[8]  = '{1, 3'b010, 32'h4, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'hAAAA2355, 0};
      vt[9]  = '{2, 3'b010, 32'h8, 32'h11112222, 1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
      vt[10] = '{0, 3'b000, 32'h12345678, 32'h0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0};
      vt[11] = '{2, 3'b000, 32'h8, 32'h00000077, 0, 1, 1, 0, 1, 32'h00000077, 1, 0, 32'h0,        0};
      vt[12] = '{1, 3'b010, 32'h8, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h00000077, 0};
      vt[13] = '{1, 3'b011, 32'h0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1};

      // Reset: a live SW during reset must not write or stall
      valid = 1'b1; mwr = 1'b1; f3 = 3'b010; alu = 32'h4; sd = 32'hFFFFFFFF;
      @(posedge clk); #4;
      chk("rst_we", {31'd0, dmif.dm_we}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      valid = 1'b0; mwr = 1'b0; rst = 1'b0;
      chk("rst_wbv", {31'd0, wbv}, 32'd0);
      chk("rst_mis", {31'd0, mis}, 32'd0);
      chk("rst_wbalu", wbalu, 32'd0);
      chk("rst_mem", mem[1], 32'd0);

      for (int i = 0; i < 14; i++) begin
         issue(vt[i].kind, vt[i].fn, vt[i].a, vt[i].d, 5'(i + 1), vt[i].kind != 2,
               vt[i].fl, vt[i].fl2, 1'b1);
         chk($sformatf("v%0d_stall", i), {31'd0, ob_stall}, {31'd0, vt[i].x_stall});
         chk($sformatf("v%0d_we1", i), {31'd0, ob_we1}, {31'd0, vt[i].x_we1});
         chk($sformatf("v%0d_we2", i), {31'd0, ob_we2}, {31'd0, vt[i].x_we2});
         if (vt[i].x_we1 || vt[i].x_we2) begin
            chk($sformatf("v%0d_wd", i), ob_wd, vt[i].x_wd);
            chk($sformatf("v%0d_waddr", i), ob_addr, {vt[i].a[31:2], 2'b00});
         end
         if (vt[i].x_stall) begin
            chk($sformatf("v%0d_bubble", i), {31'd0, ob_bub}, 32'd0);
            chk($sformatf("v%0d_stall2", i), {31'd0, ob_stall2}, 32'd0);
         end
         chk($sformatf("v%0d_wbv", i), {31'd0, wbv}, {31'd0, vt[i].x_wbv});
         chk($sformatf("v%0d_m2r", i), {31'd0, wbm2r}, {31'd0, vt[i].x_m2r});
         chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, vt[i].x_mis});
         chk($sformatf("v%0d_rw", i), {31'd0, wbrw},
             {31'd0, vt[i].x_wbv && vt[i].kind != 2 && !vt[i].x_mis});
         if (vt[i].x_m2r) chk($sformatf("v%0d_ld", i), wbld, vt[i].x_ld);
         if (vt[i].x_wbv) begin
            chk($sformatf("v%0d_alu", i), wbalu, vt[i].a);
            chk($sformatf("v%0d_rd", i), {27'd0, wbrd}, 32'(i + 1));
         end
         chk_mem($sformatf("v%0d_mem", i));
      end

      // Reset during RMW_WR of SH addr 8 aborts the write
      valid = 1'b1; mwr = 1'b1; f3 = 3'b001; alu = 32'h8; sd = 32'hDEADBEEF;
      rd = 5'd9; rwi = 1'b0;
      #4;
      chk("rmwrst_stall1", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #3;
      chk("rmwrst_we", {31'd0, dmif.dm_we}, 32'd0);
      chk("rmwrst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0; mwr = 1'b0;
      chk("rmwrst_mem8", mem[2], 32'h00000077);
      chk("rmwrst_wb", {25'd0, wbv, wbrw, wbm2r, wbrd}, 32'd0);
      chk("rmwrst_data", wbalu | wbld, 32'd0);
      chk("rmwrst_mis", {31'd0, mis}, 32'd0);
      issue(1, 3'b010, 32'h8, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rmwrst_idle", {31'd0, ob_stall}, 32'd0);
      chk("rmwrst_ld", wbld, 32'h00000077);

      // Random instructions against the model
      for (int n = 0; n < 300; n++) begin
         int          kind;
         logic [2:0]  fn;
         logic [31:0] a;
         kind = int'($urandom_range(0, 2));
         a    = (kind == 0) ? $urandom : 32'($urandom_range(0, 63));
         if (kind == 1) begin
            case ($urandom_range(0, 5))
               0: fn = 3'b000; 1: fn = 3'b001; 2: fn = 3'b010;
               3: fn = 3'b100; 4: fn = 3'b101; default: fn = 3'b110;
            endcase
         end else if (kind == 2) begin
            case ($urandom_range(0, 3))
               0: fn = 3'b000; 1: fn = 3'b001; 2: fn = 3'b010; default: fn = 3'b011;
            endcase
         end else fn = 3'($urandom_range(0, 7));
         issue(kind, fn, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
         chk("r_stall", {31'd0, ob_stall}, {31'd0, e_stall});
         chk("r_write", {31'd0, ob_we1 | ob_we2}, {31'd0, e_write});
         if (e_write) chk("r_waddr", ob_addr, {a[31:2], 2'b00});
         chk("r_wbv", {31'd0, wbv}, {31'd0, e_wbv});
         chk("r_rw", {31'd0, wbrw}, {31'd0, e_rw});
         chk("r_m2r", {31'd0, wbm2r}, {31'd0, e_m2r});
         chk("r_mis", {31'd0, mis}, {31'd0, e_mis});
         chk("r_rd", {27'd0, wbrd}, {27'd0, e_rd});
         chk("r_alu", wbalu, e_alu);
         if (e_m2r) chk("r_ld", wbld, e_ld);
         chk_mem("r_mem");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
